bcd_timer_ctrl: RTL
===================

BCD_TIMER_CTRL -- requirements
Module: bcd_timer_ctrl

Interface
REQ-001 Parameter: PRESC_W, 16, width of the prescaler divisor and counter.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  start/resume request, sampled each cycle.
REQ-005 stop  input  1  pause request.
REQ-006 clear  input  1  return to idle and zero the count.
REQ-007 lap  input  1  capture the current count.
REQ-008 div  input  PRESC_W  prescale divisor; tick period is div+1 cycles.
REQ-009 target  input  16  4-digit BCD terminal count; 16'h0000 means free-run.
REQ-010 q  output  16  4-digit BCD count {thousands, hundreds, tens, ones}.
REQ-011 lap_q  output  16  last captured count.
REQ-012 lap_valid  output  1  lap_q holds a capture since the last clear/reset.
REQ-013 state  output  2  FSM state encoding.
REQ-014 running  output  1  high exactly when state is RUN.
REQ-015 done  output  1  one-cycle pulse on reaching target.

Function
REQ-016 FSM states SHALL be IDLE=2'b00, RUN=2'b01, PAUSED=2'b10, DONE=2'b11.
REQ-017 Command priority each cycle SHALL be reset > clear > stop > start; lap is independent of the others.
REQ-018 clear in any state SHALL go to IDLE, set q=0, zero the prescaler and deassert lap_valid.
REQ-019 start in IDLE SHALL go to RUN with the prescaler zeroed; start in PAUSED SHALL go to RUN with the prescaler value retained; start in RUN or DONE SHALL be ignored.
REQ-020 stop in RUN SHALL go to PAUSED; stop in other states SHALL be ignored; start and stop asserted together SHALL behave as stop only.
REQ-021 The prescaler SHALL advance only in RUN, and a tick SHALL occur in a RUN cycle when prescaler==div; the prescaler then wraps to 0, and div=0 yields a tick every RUN cycle.
REQ-022 On a tick, q SHALL increment by one in BCD: the ones digit increments; a digit at 9 returns to 0 and carries into the next digit; 9999 wraps to 0000.
REQ-023 If a tick makes the next q equal to a non-zero, valid-BCD target, q SHALL load that value, state SHALL become DONE and done SHALL pulse high for exactly that following cycle.
REQ-024 A target with any nibble >9, or target=0000, SHALL never match, and the counter SHALL wrap freely.
REQ-025 In DONE, q SHALL hold its value until clear or reset.
REQ-026 Timing: start asserted in cycle N puts state=RUN in cycle N+1; with div=0, q=0001 is visible in cycle N+2.
REQ-027 lap in RUN, PAUSED or DONE SHALL load lap_q with the pre-edge value of q and set lap_valid on the next edge; this includes the case where a tick occurs in the same cycle.
REQ-028 lap in IDLE, or together with clear, SHALL be ignored.
REQ-029 If div changes while in RUN, the new value SHALL be used from the next compare, and a prescaler value above the new div SHALL continue counting up and wrap at 2^PRESC_W.

Reset
REQ-030 Reset SHALL force state=IDLE, q=0, lap_q=0, lap_valid=0, done=0, running=0 and prescaler=0, overriding all inputs including a reset asserted mid-count.

Structure
REQ-031 State encodings and the BCD digit width (4) SHALL live in the shared package bcd_timer_pkg.
REQ-032 One sub-module, bcd_digit, SHALL be instantiated four times: inputs clk, reset, clr, inc; outputs a 4-bit digit and a carry (inc && digit==9). Each digit's inc SHALL be the tick ANDed with all lower-digit carries.

Verification
REQ-033 div=0, target=0, start pulse -> q=0001, 0002, ... one per cycle from cycle N+2; after 9999 the next value is 0000.
REQ-034 div=3, target=0012, start -> q increments every 4 cycles; done pulses once with q=0012, state=DONE, and q holds for at least 20 further cycles.
REQ-035 div=1, run to q=0005, stop -> PAUSED with q held; start -> next tick arrives after the retained prescaler phase, giving q=0006.
REQ-036 start and stop in the same cycle while RUN -> PAUSED; lap and tick in the same cycle with q=0109 -> lap_q=0109, q=0110, lap_valid=1.
REQ-037 target=00A5 -> no done pulse across a full 0000-9999 wrap; then clear -> q=0000, lap_valid=0, state=IDLE.
REQ-038 reset asserted at q=0999 mid-RUN -> next cycle shows all outputs at their reset values.

Source files
------------

// File: rtl/bcd_timer_pkg.sv
// rtl/bcd_timer_pkg.sv - shared state encodings, digit width and BCD helpers for the BCD timer
package bcd_timer_pkg;

   localparam int DIGIT_W = 4;

   localparam logic [1:0] ST_IDLE   = 2'b00;
   localparam logic [1:0] ST_RUN    = 2'b01;
   localparam logic [1:0] ST_PAUSED = 2'b10;
   localparam logic [1:0] ST_DONE   = 2'b11;

   // A terminal count is usable only when non-zero and every nibble is a decimal digit.
   function automatic logic bcd_target_ok(input logic [4*DIGIT_W-1:0] t);
      logic ok;
      ok = (t != '0);
      for (int i = 0; i < 4; i++) begin
         if (t[i*DIGIT_W +: DIGIT_W] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

   function automatic logic [4*DIGIT_W-1:0] bcd_next(input logic [4*DIGIT_W-1:0] v);
      logic [4*DIGIT_W-1:0] r;
      logic                 c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            if (v[i*DIGIT_W +: DIGIT_W] == 4'd9) begin
               r[i*DIGIT_W +: DIGIT_W] = '0;
            end else begin
               r[i*DIGIT_W +: DIGIT_W] = v[i*DIGIT_W +: DIGIT_W] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_timer_ctrl_digit.sv
// rtl/bcd_timer_ctrl_digit.sv - one decimal digit of the BCD counter with ripple carry
module bcd_digit
   import bcd_timer_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               clr,
   input  logic               inc,
   output logic [DIGIT_W-1:0] digit,
   output logic               carry
);

   assign carry = inc && (digit == 4'd9);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         digit <= '0;
      end else if (inc) begin
         digit <= (digit == 4'd9) ? '0 : digit + 4'd1;
      end
   end

endmodule

// File: rtl/bcd_timer_ctrl.sv
// rtl/bcd_timer_ctrl.sv - prescaled 4-digit BCD up-counter with run/pause/done control and lap capture
module bcd_timer_ctrl
   import bcd_timer_pkg::*;
#(
   parameter int PRESC_W = 16
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               stop,
   input  logic               clear,
   input  logic               lap,
   input  logic [PRESC_W-1:0] div,
   input  logic [15:0]        target,
   output logic [15:0]        q,
   output logic [15:0]        lap_q,
   output logic               lap_valid,
   output logic [1:0]         state,
   output logic               running,
   output logic               done
);

   logic [PRESC_W-1:0] presc;
   logic [3:0]         inc;
   logic [3:0]         carry;
   logic               tick;
   logic               match;

   assign running = (state == ST_RUN);
   assign tick    = running && !clear && (presc == div);
   assign match   = tick && bcd_target_ok(target) && (bcd_next(q) == target);

   assign inc[0] = tick;
   for (genvar i = 1; i < 4; i++) begin : g_inc
      assign inc[i] = inc[i-1] && carry[i-1];
   end

   for (genvar i = 0; i < 4; i++) begin : g_digit
      bcd_digit u_digit (
         .clk   (clk),
         .reset (reset),
         .clr   (clear),
         .inc   (inc[i]),
         .digit (q[i*DIGIT_W +: DIGIT_W]),
         .carry (carry[i])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         presc     <= '0;
         lap_q     <= '0;
         lap_valid <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= match;
         if (clear) begin
            state     <= ST_IDLE;
            presc     <= '0;
            lap_valid <= 1'b0;
         end else begin
            if (running) begin
               presc <= (presc == div) ? '0 : presc + {{(PRESC_W-1){1'b0}}, 1'b1};
            end
            if (lap && state != ST_IDLE) begin
               lap_q     <= q;
               lap_valid <= 1'b1;
            end
            // Reaching the target completes the run even if a stop arrives in the same cycle.
            if (match) begin
               state <= ST_DONE;
            end else if (stop) begin
               if (running) state <= ST_PAUSED;
            end else if (start) begin
               if (state == ST_IDLE) begin
                  state <= ST_RUN;
                  presc <= '0;
               end else if (state == ST_PAUSED) begin
                  state <= ST_RUN;
               end
            end
         end
      end
   end

endmodule
